jpeg_block_feeder: RTL
======================

# jpeg_block_feeder

Upstream stage of the JPEG encoder peripheral. Accepts a raster-order RGB pixel stream, buffers one 8-row strip, and re-emits it as 8x8 blocks of 64 single-pixel bus writes into the encoder wrapper's data-FIFO address window. It flags the final block of the image through address bit 8, and signals completion once that block's last write is granted. This lets software or a stream source feed whole images without doing the block reordering itself.

## Interface
- `MAX_W_BLK`, default 8: maximum image width in 8-pixel blocks. Strip RAM depth = 64*MAX_W_BLK.
- `H_BLK_W`, default 8: width of the image-height field, in blocks.
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that starts an image. Ignored unless in IDLE.
- `img_w_blk` in $clog2(MAX_W_BLK+1): width in blocks. Sampled on `start`.
- `img_h_blk` in H_BLK_W: height in blocks (strips). Sampled on `start`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after the image's final write is granted.
- `pix_valid` in 1: raster pixel valid.
- `pix_ready` out 1: pixel accepted when `pix_valid && pix_ready`.
- `pix_data` in 24: RGB pixel, passed through unmodified.
- `jpeg_req` out 1: write request to the encoder.
- `jpeg_wen` out 1: constant 0 (write).
- `jpeg_add` out 10: [8] = last-block flag; all other bits 0.
- `jpeg_wdata` out 32: {8'h00, pixel}.
- `jpeg_gnt` in 1: write accepted when `jpeg_req && jpeg_gnt`.

## Operation
States:
- **IDLE**
  - Outputs: `pix_ready`=0, `jpeg_req`=0.
  - On `start` with 1 ≤ `img_w_blk` ≤ MAX_W_BLK and `img_h_blk` ≠ 0: latch config, clear counters, go to FILL.
  - Invalid config: `start` is ignored and no `done` is pulsed.
- **FILL**
  - `pix_ready`=1.
  - Each accepted pixel is written to RAM at row*8*MAX_W_BLK + col.
  - Column counter col runs 0..8*img_w_blk-1 and wraps; row increments on wrap.
  - Acceptance of pixel (row 7, last col) moves to DRAIN. `pix_ready` drops in the following cycle.
- **DRAIN**
  - Emits blocks b = 0..img_w_blk-1, left to right.
  - Within a block, pixels are emitted row-major: p = r*8+c, RAM address r*8*MAX_W_BLK + b*8 + c.
  - `jpeg_add[8]`=1 for every write of the final block of the final strip, held stable for all 64 writes. It is 0 otherwise.
  - When the last write of the strip is granted:
    - more strips remain: increment strip count, go to FILL.
    - final strip: go to DONE.
- **DONE**
  - Pulse `done` for one cycle, then go to IDLE.

Handshake rules:
- Once `jpeg_req` is asserted, it and `jpeg_add`/`jpeg_wdata` stay stable until `jpeg_gnt` is sampled high.
- `jpeg_gnt` may be withheld for arbitrary stretches, e.g. the encoder's ~34-cycle processing gap after every 64 writes. The feeder simply holds.
- `pix_valid` gaps stall FILL without losing position.

Reset:
- Asynchronous reset returns to IDLE; `jpeg_req`, `pix_ready`, `busy`, `done` all go to 0 immediately. Counters clear.
- A mid-block reset leaves the encoder partially fed. The system must reset both blocks together.

## Timing
- Strip RAM has a synchronous read with 1-cycle latency. The first `jpeg_req` of a strip asserts 2 cycles after DRAIN entry (read plus output register).
- With `jpeg_gnt` held high, one write completes per cycle with no bubbles, including across block boundaries. The next RAM address is issued on the granting cycle.
- Last granted write → `done` high 2 cycles later (DRAIN→DONE, DONE asserts).
- Single strip buffer, no ping-pong: input and output never overlap. Per-strip cost is 64*img_w_blk fill cycles plus 64*img_w_blk grants.

## Structure
- Package `jpeg_feed_pkg`:
  - state enum {IDLE, FILL, DRAIN, DONE}
  - `PIX_W`=24, `BLK_DIM`=8, `BLK_PIX`=64, `ADDR_LAST_BIT`=8
- Sub-module `jpeg_strip_ram`: 1-write/1-read synchronous RAM, 64*MAX_W_BLK x 24, with registered read data.
- Top level: FSM, counters (col, row, blk, pix, strip), address generation, output register.

## Test plan
- **1x1-block image:** 64 pixels of value i.
  - 64 writes with `jpeg_wdata`=i in order, all with `jpeg_add`=10'h100.
  - `done` pulses once; `busy` then 0.
- **2x2-block image:** raster pixel value = y*16+x.
  - Write sequence per strip: block 0 then block 1. Each block carries 64 row-major values (e.g. block 1 of strip 0 starts 8,9,..,15,24).
  - `add[8]`=1 only on the last 64 writes.
- **Grant stalls:** `jpeg_gnt` low for 34 cycles after every 64th write and toggled randomly otherwise.
  - Every word is held stable while ungranted.
  - Sequence is identical to the ungated run.
- **Input gaps:** `pix_valid` random at 30%, width 8 blocks (MAX).
  - No pixel lost or duplicated.
  - `pix_ready`=0 throughout DRAIN.
- **Start handling:**
  - `start` while busy: ignored.
  - `start` with `img_w_blk`=0 or 9: no state change, `busy` stays 0.
- **Reset mid-DRAIN** (after write 20):
  - `jpeg_req` drops asynchronously.
  - A fresh 1x1 image then runs correctly from pixel 0.

Source files
------------

// File: rtl/jpeg_feed_pkg.sv
// Shared types and constants for the JPEG block feeder.
package jpeg_feed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned PIX_W         = 24;
    localparam int unsigned BLK_DIM       = 8;
    localparam int unsigned BLK_PIX       = 64;
    localparam int unsigned ADDR_LAST_BIT = 8;

endpackage

// File: rtl/jpeg_strip_ram.sv
// One-strip pixel buffer: single write port, single read port with registered read data.
module jpeg_strip_ram
    import jpeg_feed_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // rdata holds its value while re is low, so it doubles as a pipeline stage
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jpeg_block_feeder.sv
// Buffers one 8-row raster strip and re-emits it as 8x8 blocks of single-pixel bus writes.
module jpeg_block_feeder
    import jpeg_feed_pkg::*;
#(
    parameter int unsigned MAX_W_BLK = 8,
    parameter int unsigned H_BLK_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_W_BLK+1)-1:0] img_w_blk,
    input  logic [H_BLK_W-1:0]             img_h_blk,
    output logic                           busy,
    output logic                           done,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [PIX_W-1:0]               pix_data,
    output logic                           jpeg_req,
    output logic                           jpeg_wen,
    output logic [9:0]                     jpeg_add,
    output logic [31:0]                    jpeg_wdata,
    input  logic                           jpeg_gnt
);

    localparam int unsigned WW        = $clog2(MAX_W_BLK + 1);
    localparam int unsigned DEPTH     = BLK_PIX * MAX_W_BLK;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = $clog2(BLK_DIM * MAX_W_BLK);
    localparam int unsigned ROW_PITCH = BLK_DIM * MAX_W_BLK;

    state_t               state, next_state;
    logic [WW-1:0]        w_q;
    logic [H_BLK_W-1:0]   h_q;
    logic [CW-1:0]        col;
    logic [2:0]           row;
    logic [WW-1:0]        blk;
    logic [5:0]           pix;
    logic [H_BLK_W-1:0]   strip;
    logic                 rd_valid, rd_done, rd_last;
    logic                 out_last;
    logic [PIX_W-1:0]     out_pix;
    logic [PIX_W-1:0]     rd_data;

    logic                 cfg_ok, start_ok;
    logic                 pix_acc, fill_last;
    logic                 load_out, issue, strip_end;
    logic                 last_strip, last_blk;
    logic [CW-1:0]        col_max;
    logic [AW-1:0]        waddr, raddr;

    assign cfg_ok     = (img_w_blk != '0) && (32'(img_w_blk) <= MAX_W_BLK) && (img_h_blk != '0);
    assign col_max    = CW'(32'(w_q) * BLK_DIM - 32'd1);
    assign last_strip = (strip == H_BLK_W'(h_q - H_BLK_W'(1)));
    assign last_blk   = (blk == WW'(w_q - WW'(1)));

    assign pix_acc    = (state == FILL) && pix_valid && pix_ready;
    assign fill_last  = pix_acc && (row == 3'd7) && (col == col_max);

    // Two-stage read pipeline: RAM data register feeding the bus output register
    assign load_out   = rd_valid && (!jpeg_req || jpeg_gnt);
    assign issue      = (state == DRAIN) && !rd_done && (!rd_valid || load_out);
    assign strip_end  = (state == DRAIN) && rd_done && !rd_valid && jpeg_req && jpeg_gnt;

    assign waddr = AW'(row) * AW'(ROW_PITCH) + AW'(col);
    assign raddr = AW'(pix[5:3]) * AW'(ROW_PITCH) + AW'(blk) * AW'(BLK_DIM) + AW'(pix[2:0]);

    jpeg_strip_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (pix_acc),
        .waddr (waddr),
        .wdata (pix_data),
        .re    (issue),
        .raddr (raddr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    start_ok   = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                if (fill_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (strip_end) begin
                    next_state = last_strip ? DONE : FILL;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Config latch, fill position, and drain read-issue counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q      <= '0;
            h_q      <= '0;
            col      <= '0;
            row      <= '0;
            blk      <= '0;
            pix      <= '0;
            strip    <= '0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            if (start_ok) begin
                w_q     <= img_w_blk;
                h_q     <= img_h_blk;
                col     <= '0;
                row     <= '0;
                blk     <= '0;
                pix     <= '0;
                strip   <= '0;
                rd_done <= 1'b0;
            end
            if (pix_acc) begin
                if (col == col_max) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (fill_last) begin
                blk     <= '0;
                pix     <= '0;
                rd_done <= 1'b0;
            end
            if (issue) begin
                rd_last <= last_strip && last_blk;
                if (pix == 6'(BLK_PIX - 1)) begin
                    pix <= '0;
                    blk <= blk + WW'(1);
                    if (last_blk) begin
                        rd_done <= 1'b1;
                    end
                end else begin
                    pix <= pix + 6'd1;
                end
            end
            if (strip_end && !last_strip) begin
                strip <= strip + H_BLK_W'(1);
            end
            rd_valid <= issue || (rd_valid && !load_out);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
            jpeg_req  <= 1'b0;
            out_last  <= 1'b0;
            out_pix   <= '0;
        end else begin
            busy      <= (next_state != IDLE);
            done      <= (state == DONE);
            pix_ready <= (next_state == FILL);
            if (load_out) begin
                jpeg_req <= 1'b1;
                out_last <= rd_last;
                out_pix  <= rd_data;
            end else if (jpeg_gnt) begin
                jpeg_req <= 1'b0;
            end
        end
    end

    always_comb begin
        jpeg_add                = '0;
        jpeg_add[ADDR_LAST_BIT] = out_last;
    end

    assign jpeg_wen   = 1'b0;
    assign jpeg_wdata = {8'h00, out_pix};

endmodule
